pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 113 +++++++++++
 tb/tb_pipe_skid_reg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: main drives data_o, skid absorbs the beat accepted
// in the cycle downstream stalls, so ready_o can come straight from a flop.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    valid_o = 1'b0;
    ready_o = 1'b1;
    count_o = 2'd0;
    unique case (state_q)
      StEmpty: begin
        valid_o = 1'b0;
        ready_o = 1'b1;
        count_o = 2'd0;
      end
      StOne: begin
        valid_o = 1'b1;
        ready_o = 1'b1;
        count_o = 2'd1;
      end
      StFull: begin
        valid_o = 1'b1;
        ready_o = 1'b0;
        count_o = 2'd2;
      end
      default: begin
        valid_o = 1'b0;
        ready_o = 1'b1;
        count_o = 2'd0;
      end
    endcase
  end

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;
  assign data_o   = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          main_d  = data_i;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = data_i;
        end else if (in_fire) begin
          state_d = StFull;
          skid_d  = data_i;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops occupancy but leaves the data registers untouched.
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a 64-bit and an 8-bit instance share the same
// handshake stimulus and are checked against a queue-based occupancy model.
module tb_pipe_skid_reg;

  localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;
  localparam logic [7:0]  RV8  = 8'hC3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [63:0] data_i = '0;

  logic        ready_o, valid_o;
  logic [63:0] data_o;
  logic [1:0]  count_o;
  logic        ready_o8, valid_o8;
  logic [7:0]  data_o8;
  logic [1:0]  count_o8;
  logic [7:0]  data_i8;

  assign data_i8 = data_i[7:0];

  pipe_skid_reg #(.WIDTH(64), .RESET_VAL(RV64)) u_dut64 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o8),
    .data_i  (data_i8),
    .valid_o (valid_o8),
    .ready_i (ready_i),
    .data_o  (data_o8),
    .count_o (count_o8)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          occ = 0;
  int          n_out = 0;
  bit          mon_en = 1'b0;
  bit          last_in = 1'b0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference model: occupancy is just the number of accepted-but-unconsumed payloads,
  // capped at two; acceptance is decided by the occupancy before the edge.
  always @(posedge clk) begin
    bit do_in;
    bit do_out;
    do_in  = valid_i && (occ < 2);
    do_out = (occ > 0) && ready_i;
    last_in = 1'b0;
    if (!rst_n) begin
      occ = 0;
      exp_q.delete();
    end else if (flush_i) begin
      occ = 0;
      exp_q.delete();
    end else begin
      occ = occ + int'(do_in) - int'(do_out);
      if (do_in) begin
        exp_q.push_back(data_i);
        last_in = 1'b1;
      end
    end
  end

  // Monitor: compares handshake outputs with the model every cycle and pops the
  // expected payload whenever a transfer is about to complete.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count64", {62'd0, count_o}, 64'(occ));
      chk("count8", {62'd0, count_o8}, 64'(occ));
      chk("valid64", {63'd0, valid_o}, {63'd0, occ != 0});
      chk("valid8", {63'd0, valid_o8}, {63'd0, occ != 0});
      chk("ready64", {63'd0, ready_o}, {63'd0, occ != 2});
      chk("ready8", {63'd0, ready_o8}, {63'd0, occ != 2});
      if (occ > 0) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(exp_q.size()), 64'(occ));
        end else begin
          chk("data64", data_o, exp_q[0]);
          chk("data8", {56'd0, data_o8}, {56'd0, exp_q[0][7:0]});
          if (ready_i) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] d);
    valid_i = 1'b1;
    data_i  = d;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (last_in) begin
        valid_i = 1'b0;
        return;
      end
    end
    valid_i = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (occ == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 64'(occ), 64'd0);
  endtask

  task automatic wait_neg();
    @(negedge clk);
  endtask

  initial begin
    // Reset held for two cycles with a live upstream beat.
    rst_n   = 1'b0;
    valid_i = 1'b1;
    data_i  = 64'h0000_0000_DEAD_BEEF;
    ready_i = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    valid_i = 1'b0;
    wait_neg();
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_count", {62'd0, count_o}, 64'd0);
    chk("rst_data64", data_o, RV64);
    chk("rst_data8", {56'd0, data_o8}, {56'd0, RV8});
    @(posedge clk);
    #1;

    // Streaming 0x1..0x10 with downstream always ready.
    ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) send(64'(i));
    drain();
    chk("stream_out", 64'(n_out), 64'd16);

    // Backpressure: A and B held, C refused until downstream drains.
    ready_i = 1'b0;
    send(64'hA);
    send(64'hB);
    valid_i = 1'b1;
    data_i  = 64'hC;
    repeat (3) @(posedge clk);
    #1;
    wait_neg();
    chk("bp_count", {62'd0, count_o}, 64'd2);
    chk("bp_ready", {63'd0, ready_o}, 64'd0);
    chk("bp_data", data_o, 64'hA);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    send(64'hC);
    drain();
    chk("bp_out", 64'(n_out), 64'd19);

    // Flush while full with a new beat offered.
    ready_i = 1'b0;
    send(64'hA);
    send(64'hB);
    valid_i = 1'b1;
    data_i  = 64'h77;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    wait_neg();
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
    chk("flush_ready", {63'd0, ready_o}, 64'd1);
    chk("flush_count", {62'd0, count_o}, 64'd0);
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_out", 64'(n_out), 64'd19);

    // Reset while full and downstream ready.
    ready_i = 1'b0;
    send(64'h55);
    send(64'h66);
    ready_i = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_neg();
    chk("rstfull_valid", {63'd0, valid_o}, 64'd0);
    chk("rstfull_count", {62'd0, count_o}, 64'd0);
    chk("rstfull_data", data_o, RV64);
    @(posedge clk);
    #1;

    // Random traffic with shifting valid/ready bias, rare flush and reset.
    for (int c = 0; c < 10000; c++) begin
      int vb;
      int rb;
      vb = (c / 1000) % 4;
      rb = (c / 700) % 4;
      valid_i = ($urandom_range(0, 3) >= vb);
      ready_i = ($urandom_range(0, 3) >= rb);
      data_i  = {$urandom, $urandom};
      flush_i = ($urandom_range(0, 79) == 0);
      rst_n   = ($urandom_range(0, 399) != 0);
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    rst_n   = 1'b1;
    drain();
    chk("rand_emitted", {63'd0, n_out > 2000}, 64'd1);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
